// File: rtl/vga_timing_gen_pkg.sv
// Default 640x480@60 raster constants, coordinate/frame widths and a window-decode helper.
package vga_pkg;
  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FRONT   = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BACK    = 48;
  localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FRONT   = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BACK    = 33;
  localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned FRAME_W = 16;

  function automatic logic in_window(input logic [COORD_W-1:0] v,
                                     input int unsigned lo,
                                     input int unsigned len);
    return (32'(v) >= lo) && (32'(v) < lo + len);
  endfunction
endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: coordinates, syncs, active flag, strobes and frame counter.
interface vga_timing_gen_if;
  import vga_pkg::*;

  logic [COORD_W-1:0] DrawX;
  logic [COORD_W-1:0] DrawY;
  logic               blank;
  logic               hs;
  logic               vs;
  logic               hs_d;
  logic               vs_d;
  logic               blank_d;
  logic               line_start;
  logic               frame_start;
  logic [FRAME_W-1:0] frame_count;

  modport master (
    output DrawX, DrawY, blank, hs, vs, hs_d, vs_d, blank_d,
           line_start, frame_start, frame_count
  );

  modport slave (
    input DrawX, DrawY, blank, hs, vs, hs_d, vs_d, blank_d,
          line_start, frame_start, frame_count
  );
endinterface

// File: rtl/vga_timing_gen_sync_delay_line.sv
// Single-bit shift register of DEPTH (>=1) stages, every stage resetting to RST_VAL.
// Output lags input by exactly DEPTH clock edges.
module sync_delay_line #(
  parameter int unsigned DEPTH   = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);
  logic [DEPTH-1:0] sr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q <= {DEPTH{RST_VAL}};
    end else begin
      sr_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        sr_q[i] <= sr_q[i-1];
      end
    end
  end

  assign q_o = sr_q[DEPTH-1];
endmodule

// File: rtl/vga_timing_gen.sv
// Free-running raster timing generator; all strobes registered from next-state counters.
// Undelayed outputs align with DrawX/DrawY; *_d outputs lag them by PIPE_DELAY cycles.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE  = vga_pkg::H_VISIBLE,
  parameter int unsigned H_FRONT    = vga_pkg::H_FRONT,
  parameter int unsigned H_SYNC     = vga_pkg::H_SYNC,
  parameter int unsigned H_BACK     = vga_pkg::H_BACK,
  parameter int unsigned V_VISIBLE  = vga_pkg::V_VISIBLE,
  parameter int unsigned V_FRONT    = vga_pkg::V_FRONT,
  parameter int unsigned V_SYNC     = vga_pkg::V_SYNC,
  parameter int unsigned V_BACK     = vga_pkg::V_BACK,
  parameter int unsigned PIPE_DELAY = 2
) (
  input  logic             vga_clk,
  input  logic             reset_n,
  vga_timing_gen_if.master vga
);
  localparam int unsigned H_TOT    = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOT    = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
  localparam int unsigned VS_START = V_VISIBLE + V_FRONT;

  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic               hsync_q, hsync_d, vsync_q, vsync_d;
  logic               act_q, act_d, lstart_q, lstart_d, fstart_q, fstart_d;
  logic [FRAME_W-1:0] fcnt_q, fcnt_d;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q      <= '0;
      y_q      <= '0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      act_q    <= 1'b0;
      lstart_q <= 1'b0;
      fstart_q <= 1'b0;
      fcnt_q   <= '0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      act_q    <= act_d;
      lstart_q <= lstart_d;
      fstart_q <= fstart_d;
      fcnt_q   <= fcnt_d;
    end
  end

  // Strobes decode the next-state counters so they register in step with them.
  always_comb begin
    x_d = x_q + COORD_W'(1);
    y_d = y_q;
    if (x_q == COORD_W'(H_TOT - 1)) begin
      x_d = '0;
      y_d = (y_q == COORD_W'(V_TOT - 1)) ? '0 : y_q + COORD_W'(1);
    end
    hsync_d  = !in_window(x_d, HS_START, H_SYNC);
    vsync_d  = !in_window(y_d, VS_START, V_SYNC);
    act_d    = (x_d < COORD_W'(H_VISIBLE)) && (y_d < COORD_W'(V_VISIBLE));
    lstart_d = (x_d == '0);
    fstart_d = lstart_d && (y_d == '0);
    fcnt_d   = fcnt_q + FRAME_W'(fstart_d);
  end

  assign vga.DrawX       = x_q;
  assign vga.DrawY       = y_q;
  assign vga.hs          = hsync_q;
  assign vga.vs          = vsync_q;
  assign vga.blank       = act_q;
  assign vga.line_start  = lstart_q;
  assign vga.frame_start = fstart_q;
  assign vga.frame_count = fcnt_q;

  generate
    if (PIPE_DELAY == 0) begin : g_nodly
      assign vga.hs_d    = hsync_q;
      assign vga.vs_d    = vsync_q;
      assign vga.blank_d = act_q;
    end else begin : g_dly
      sync_delay_line #(.DEPTH(PIPE_DELAY), .RST_VAL(1'b1)) u_hs (
        .clk_i(vga_clk), .rst_ni(reset_n), .d_i(hsync_q), .q_o(vga.hs_d));
      sync_delay_line #(.DEPTH(PIPE_DELAY), .RST_VAL(1'b1)) u_vs (
        .clk_i(vga_clk), .rst_ni(reset_n), .d_i(vsync_q), .q_o(vga.vs_d));
      sync_delay_line #(.DEPTH(PIPE_DELAY), .RST_VAL(1'b0)) u_blank (
        .clk_i(vga_clk), .rst_ni(reset_n), .d_i(act_q), .q_o(vga.blank_d));
    end
  endgenerate
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Free-running raster timing generator for 640x480@60 Hz, sitting directly upstream of every sprite mapper and the final colour mux. It produces the pixel coordinates `DrawX`/`DrawY` and the active-video flag `blank` that the mappers consume. It also produces sync pulses delayed to line up with the mappers' registered RGB output. Per-frame and per-line strobes plus a frame counter feed game/animation logic.

## Interface
Parameters:
- `H_VISIBLE`, 640: active pixels per line
- `H_FRONT`, 16: horizontal front porch
- `H_SYNC`, 96: horizontal sync width
- `H_BACK`, 48: horizontal back porch
- `V_VISIBLE`, 480: active lines
- `V_FRONT`, 10: vertical front porch
- `V_SYNC`, 2: vertical sync width
- `V_BACK`, 33: vertical back porch
- `PIPE_DELAY`, 2: delay in cycles applied to the `*_d` outputs; legal range 0..4

Ports:
- `vga_clk` in 1: pixel clock, 25 MHz
- `reset_n` in 1: asynchronous, active-low reset
- `DrawX` out 10: current column, 0..799
- `DrawY` out 10: current row, 0..524
- `blank` out 1: 1 = active video (`DrawX<640 && DrawY<480`)
- `hs`, `vs` out 1: active-low syncs, aligned with `DrawX`/`DrawY`
- `hs_d`, `vs_d`, `blank_d` out 1: the same signals delayed by `PIPE_DELAY` cycles, for the monitor pins
- `line_start` out 1: one-cycle pulse while `DrawX==0`
- `frame_start` out 1: one-cycle pulse while `DrawX==0 && DrawY==0`
- `frame_count` out 16: number of frames completed, wraps

Reset is asynchronous and active-low on `reset_n`. There is one clock, `vga_clk`.

## Operation
- `H_TOTAL` = 800 and `V_TOTAL` = 525; both are the sums of their respective parameters.
- `DrawX` increments every cycle. It wraps 799→0.
- `DrawY` increments only on the cycle where `DrawX` wraps. `DrawY` wraps 524→0 on the same edge that `DrawX` wraps 799→0.
- `hs`=0 iff `DrawX` is in [656,751]. `vs`=0 iff `DrawY` is in [490,491]. Both boundaries are derived from the parameters, not hard-coded.
- `hs`, `vs`, `blank`, `line_start` and `frame_start` are registered. They are decoded from the next-state counter values, so they are valid in the same cycle as the matching `DrawX`/`DrawY`. They are glitch-free.
- `frame_count` increments on the edge where `frame_start` rises. It wraps 0xFFFF→0.
- The delay line is a shift register of depth `PIPE_DELAY`. With `PIPE_DELAY`=0 the `*_d` outputs equal their undelayed versions combinationally.
- All counter arithmetic is unsigned 10-bit. Out-of-range counter values are unreachable.

## Timing
- Reset values: `DrawX`=0, `DrawY`=0, `hs`=1, `vs`=1, `blank`=0, `line_start`=0, `frame_start`=0, `frame_count`=0. Every delay-line stage resets to `hs_d`=1, `vs_d`=1, `blank_d`=0.
- First cycle after reset release: the counters sit at (0,0) with `blank`=0 and `frame_start`=0, because they hold their reset values. The first edge moves the counters to (1,0) with `blank`=1. Pixel (0,0) of the first frame only is blanked; this is intended.
- The first `frame_start` pulse occurs 420000 cycles after reset release.
- Reset asserted mid-frame forces all outputs to their reset values immediately. Counting restarts cleanly.
- Line period is 800 cycles. Frame period is 420000 cycles.
- `hs_d`/`vs_d`/`blank_d` lag `hs`/`vs`/`blank` by exactly `PIPE_DELAY` edges. This matches the mappers' ROM read plus output register.

## Structure
- Package `vga_pkg` holds:
  - the default timing constants (`H_*`, `V_*`, `H_TOTAL`, `V_TOTAL`);
  - `localparam` widths `COORD_W`=10 and `FRAME_W`=16.
- The sub-module `sync_delay_line` is a parameterised-depth, reset-valued shift register. It is instantiated for the `hs`, `vs` and `blank` bits.

## Test plan
- **Reset release:** after release, `DrawX` reaches 639 at cycle 639 with `blank`=1; at `DrawX`=640 `blank` goes to 0. `hs` falls at `DrawX`=656 and rises at `DrawX`=752.
- **Line wrap:** at (799,0) the next cycle is (0,1) with `line_start`=1 for exactly one cycle; `blank`=1 on that cycle.
- **Frame wrap:**
  - `vs` is low only for `DrawY` 490–491.
  - at (799,524) the next cycle is (0,0) with `frame_start`=1 and `frame_count` 0→1.
  - the interval between `frame_start` pulses is 420000 cycles.
- **Delay alignment:** with `PIPE_DELAY`=2, `hs_d` falls exactly 2 cycles after `hs`, i.e. at `DrawX`=658. Also re-run with `PIPE_DELAY`=0 and check `hs_d`==`hs` on every cycle.
- **Mid-frame reset:** assert `reset_n`=0 at (300,200). The outputs go to their reset values asynchronously, before the next edge. After release, `DrawX` counts from 0 and `frame_count`=0.
- **Counter wrap:** force `frame_count`=0xFFFF; the next `frame_start` yields `frame_count`=0x0000.
